// File: rtl/warp_issue_scheduler.sv
// warp_issue_scheduler: round-robin pick of one hazard-free warp head per cycle into a single-entry issue stage.
// Latency: ibuf head to issue_valid is 1 cycle; sustains 1 instruction/cycle while issue_ready stays high.
// Backpressure: issue stage holds stable while issue_valid && !issue_ready; no warp is dequeued then.
//
// Ports:
//   clock, reset        : clock and synchronous active-high reset
//   ibuf_*              : per-warp instruction-buffer heads (packed, warp g at [W*g +: W]); ibuf_ready is the one-hot dequeue
//   issue_*             : registered issue stage with valid/ready handshake toward operand collect / execute
//   wb_valid/wid/rd     : writeback event, clears the matching scoreboard bit
//   sb_busy             : per-warp OR of the registered scoreboard (any write pending)
// Optional build macro: ISSUE_WB_BYPASS_EN -- a same-cycle writeback is visible to eligibility.
module warp_issue_scheduler #(
  parameter int NUM_WARPS = 8,
  parameter int WID_BITS  = $clog2(NUM_WARPS),
  parameter int NUM_LANES = 16,
  parameter int ARCH_LEN  = 32,
  parameter int OP_BITS   = 9,
  parameter int REG_BITS  = 8,
  parameter int INST_BITS = 64
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_WARPS-1:0]            ibuf_valid,
  output logic [NUM_WARPS-1:0]            ibuf_ready,
  input  logic [NUM_WARPS*ARCH_LEN-1:0]   ibuf_pc,
  input  logic [NUM_WARPS*OP_BITS-1:0]    ibuf_op,
  input  logic [NUM_WARPS*REG_BITS-1:0]   ibuf_rd,
  input  logic [NUM_WARPS*REG_BITS-1:0]   ibuf_rs1,
  input  logic [NUM_WARPS*REG_BITS-1:0]   ibuf_rs2,
  input  logic [NUM_WARPS*REG_BITS-1:0]   ibuf_rs3,
  input  logic [NUM_WARPS*NUM_LANES-1:0]  ibuf_tmask,
  input  logic [NUM_WARPS*INST_BITS-1:0]  ibuf_raw,
  output logic                            issue_valid,
  input  logic                            issue_ready,
  output logic [WID_BITS-1:0]             issue_wid,
  output logic [ARCH_LEN-1:0]             issue_pc,
  output logic [OP_BITS-1:0]              issue_op,
  output logic [REG_BITS-1:0]             issue_rd,
  output logic [REG_BITS-1:0]             issue_rs1,
  output logic [REG_BITS-1:0]             issue_rs2,
  output logic [REG_BITS-1:0]             issue_rs3,
  output logic [NUM_LANES-1:0]            issue_tmask,
  output logic [INST_BITS-1:0]            issue_raw,
  input  logic                            wb_valid,
  input  logic [WID_BITS-1:0]             wb_wid,
  input  logic [REG_BITS-1:0]             wb_rd,
  output logic [NUM_WARPS-1:0]            sb_busy
);

  localparam int NUM_REGS = 2 ** REG_BITS;

`ifdef ISSUE_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // Scoreboard: one row per warp, bit r set while a write to register r is in flight.
  logic [NUM_REGS-1:0]  r_sb [NUM_WARPS];
  logic [WID_BITS-1:0]  r_ptr;

  logic                 r_issue_valid;
  logic [WID_BITS-1:0]  r_issue_wid;
  logic [ARCH_LEN-1:0]  r_issue_pc;
  logic [OP_BITS-1:0]   r_issue_op;
  logic [REG_BITS-1:0]  r_issue_rd;
  logic [REG_BITS-1:0]  r_issue_rs1;
  logic [REG_BITS-1:0]  r_issue_rs2;
  logic [REG_BITS-1:0]  r_issue_rs3;
  logic [NUM_LANES-1:0] r_issue_tmask;
  logic [INST_BITS-1:0] r_issue_raw;

  logic                 w_adv;
  logic                 w_found;
  logic                 w_do_grant;
  logic [WID_BITS-1:0]  w_grant;
  int                   w_scan;
  logic [NUM_WARPS-1:0] w_wb_hit;
  logic [NUM_WARPS-1:0] w_elig;
  logic [NUM_REGS-1:0]  w_sb_eff [NUM_WARPS];

  logic [ARCH_LEN-1:0]  w_sel_pc;
  logic [OP_BITS-1:0]   w_sel_op;
  logic [REG_BITS-1:0]  w_sel_rd;
  logic [REG_BITS-1:0]  w_sel_rs1;
  logic [REG_BITS-1:0]  w_sel_rs2;
  logic [REG_BITS-1:0]  w_sel_rs3;
  logic [NUM_LANES-1:0] w_sel_tmask;
  logic [INST_BITS-1:0] w_sel_raw;

  assign w_adv = !r_issue_valid || issue_ready;

  // Out-of-range wb_wid never matches any row, so it is ignored for free.
  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      w_wb_hit[w] = wb_valid && (wb_wid == WID_BITS'(w)) && (wb_rd != '0);
    end
  end

  // Effective scoreboard used for the hazard check; register 0 always reads clear.
  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      w_sb_eff[w] = r_sb[w];
      if (BYPASS && w_wb_hit[w]) begin
        w_sb_eff[w][wb_rd] = 1'b0;
      end
      w_sb_eff[w][0] = 1'b0;
      w_elig[w] = ibuf_valid[w]
                  && !w_sb_eff[w][ibuf_rd [REG_BITS*w +: REG_BITS]]
                  && !w_sb_eff[w][ibuf_rs1[REG_BITS*w +: REG_BITS]]
                  && !w_sb_eff[w][ibuf_rs2[REG_BITS*w +: REG_BITS]]
                  && !w_sb_eff[w][ibuf_rs3[REG_BITS*w +: REG_BITS]];
    end
  end

  // Round-robin scan starting at r_ptr; first eligible warp wins.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_scan  = 0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      w_scan = (int'(r_ptr) + i) % NUM_WARPS;
      if (!w_found && w_elig[w_scan]) begin
        w_found = 1'b1;
        w_grant = WID_BITS'(w_scan);
      end
    end
  end

  assign w_do_grant = w_found && w_adv && !reset;

  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      ibuf_ready[w] = w_do_grant && (w_grant == WID_BITS'(w));
    end
  end

  // Field mux for the granted warp.
  always_comb begin
    w_sel_pc    = '0;
    w_sel_op    = '0;
    w_sel_rd    = '0;
    w_sel_rs1   = '0;
    w_sel_rs2   = '0;
    w_sel_rs3   = '0;
    w_sel_tmask = '0;
    w_sel_raw   = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (w_grant == WID_BITS'(w)) begin
        w_sel_pc    = ibuf_pc   [ARCH_LEN*w  +: ARCH_LEN];
        w_sel_op    = ibuf_op   [OP_BITS*w   +: OP_BITS];
        w_sel_rd    = ibuf_rd   [REG_BITS*w  +: REG_BITS];
        w_sel_rs1   = ibuf_rs1  [REG_BITS*w  +: REG_BITS];
        w_sel_rs2   = ibuf_rs2  [REG_BITS*w  +: REG_BITS];
        w_sel_rs3   = ibuf_rs3  [REG_BITS*w  +: REG_BITS];
        w_sel_tmask = ibuf_tmask[NUM_LANES*w +: NUM_LANES];
        w_sel_raw   = ibuf_raw  [INST_BITS*w +: INST_BITS];
      end
    end
  end

  // Issue stage and round-robin pointer.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ptr         <= '0;
      r_issue_valid <= 1'b0;
      r_issue_wid   <= '0;
      r_issue_pc    <= '0;
      r_issue_op    <= '0;
      r_issue_rd    <= '0;
      r_issue_rs1   <= '0;
      r_issue_rs2   <= '0;
      r_issue_rs3   <= '0;
      r_issue_tmask <= '0;
      r_issue_raw   <= '0;
    end else if (w_adv) begin
      if (w_found) begin
        r_issue_valid <= 1'b1;
        r_issue_wid   <= w_grant;
        r_issue_pc    <= w_sel_pc;
        r_issue_op    <= w_sel_op;
        r_issue_rd    <= w_sel_rd;
        r_issue_rs1   <= w_sel_rs1;
        r_issue_rs2   <= w_sel_rs2;
        r_issue_rs3   <= w_sel_rs3;
        r_issue_tmask <= w_sel_tmask;
        r_issue_raw   <= w_sel_raw;
        r_ptr         <= (w_grant == WID_BITS'(NUM_WARPS - 1)) ? '0 : w_grant + WID_BITS'(1);
      end else begin
        r_issue_valid <= 1'b0;
      end
    end
  end

  // Scoreboard update: clear first, then set, so a same-cycle set wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        r_sb[w] <= '0;
      end
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (w_wb_hit[w]) begin
          r_sb[w][wb_rd] <= 1'b0;
        end
        if (w_do_grant && (w_grant == WID_BITS'(w)) && (w_sel_rd != '0)) begin
          r_sb[w][w_sel_rd] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      sb_busy[w] = |r_sb[w];
    end
  end

  assign issue_valid = r_issue_valid;
  assign issue_wid   = r_issue_wid;
  assign issue_pc    = r_issue_pc;
  assign issue_op    = r_issue_op;
  assign issue_rd    = r_issue_rd;
  assign issue_rs1   = r_issue_rs1;
  assign issue_rs2   = r_issue_rs2;
  assign issue_rs3   = r_issue_rs3;
  assign issue_tmask = r_issue_tmask;
  assign issue_raw   = r_issue_raw;

endmodule

// File: tb/tb_warp_issue_scheduler.sv
module tb_warp_issue_scheduler;
  localparam int NW = 8;
  localparam int NL = 16;
  localparam int AL = 32;
  localparam int OB = 9;
  localparam int RB = 8;
  localparam int IB = 64;
  localparam int WB = 3;

  logic            clock = 1'b0;
  logic            reset;
  logic [NW-1:0]   ibuf_valid;
  logic [NW-1:0]   ibuf_ready;
  logic [NW*AL-1:0] ibuf_pc;
  logic [NW*OB-1:0] ibuf_op;
  logic [NW*RB-1:0] ibuf_rd, ibuf_rs1, ibuf_rs2, ibuf_rs3;
  logic [NW*NL-1:0] ibuf_tmask;
  logic [NW*IB-1:0] ibuf_raw;
  logic            issue_valid, issue_ready;
  logic [WB-1:0]   issue_wid;
  logic [AL-1:0]   issue_pc;
  logic [OB-1:0]   issue_op;
  logic [RB-1:0]   issue_rd, issue_rs1, issue_rs2, issue_rs3;
  logic [NL-1:0]   issue_tmask;
  logic [IB-1:0]   issue_raw;
  logic            wb_valid;
  logic [WB-1:0]   wb_wid;
  logic [RB-1:0]   wb_rd;
  logic [NW-1:0]   sb_busy;

  always #5 clock = ~clock;

  warp_issue_scheduler dut (
    .clock(clock), .reset(reset),
    .ibuf_valid(ibuf_valid), .ibuf_ready(ibuf_ready),
    .ibuf_pc(ibuf_pc), .ibuf_op(ibuf_op),
    .ibuf_rd(ibuf_rd), .ibuf_rs1(ibuf_rs1), .ibuf_rs2(ibuf_rs2), .ibuf_rs3(ibuf_rs3),
    .ibuf_tmask(ibuf_tmask), .ibuf_raw(ibuf_raw),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_wid(issue_wid),
    .issue_pc(issue_pc), .issue_op(issue_op),
    .issue_rd(issue_rd), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rs3(issue_rs3),
    .issue_tmask(issue_tmask), .issue_raw(issue_raw),
    .wb_valid(wb_valid), .wb_wid(wb_wid), .wb_rd(wb_rd),
    .sb_busy(sb_busy)
  );

  // Instruction-buffer heads held by the bench; replaced only when dequeued.
  logic [AL-1:0] h_pc  [NW];
  logic [OB-1:0] h_op  [NW];
  logic [RB-1:0] h_rd  [NW];
  logic [RB-1:0] h_rs1 [NW];
  logic [RB-1:0] h_rs2 [NW];
  logic [RB-1:0] h_rs3 [NW];
  logic [NL-1:0] h_tm  [NW];
  logic [IB-1:0] h_raw [NW];
  bit rand_regs;

  // Reference model: pending-write sets per warp, rotating priority start, issue slot contents.
  bit [255:0]    m_sb [NW];
  int            m_ptr;
  bit            m_valid;
  int            m_wid;
  logic [AL-1:0] m_pc;
  logic [OB-1:0] m_op;
  logic [RB-1:0] m_rd, m_rs1, m_rs2, m_rs3;
  logic [NL-1:0] m_tm;
  logic [IB-1:0] m_raw;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refill(input int w);
    h_pc[w]  = $urandom;
    h_op[w]  = OB'($urandom);
    h_tm[w]  = NL'($urandom);
    h_raw[w] = {$urandom, $urandom};
    if (rand_regs) begin
      h_rd[w]  = RB'($urandom_range(0, 7));
      h_rs1[w] = RB'($urandom_range(0, 7));
      h_rs2[w] = RB'($urandom_range(0, 7));
      h_rs3[w] = RB'($urandom_range(0, 7));
    end else begin
      h_rd[w] = '0; h_rs1[w] = '0; h_rs2[w] = '0; h_rs3[w] = '0;
    end
  endtask

  task automatic pack();
    for (int w = 0; w < NW; w++) begin
      ibuf_pc[AL*w +: AL]    = h_pc[w];
      ibuf_op[OB*w +: OB]    = h_op[w];
      ibuf_rd[RB*w +: RB]    = h_rd[w];
      ibuf_rs1[RB*w +: RB]   = h_rs1[w];
      ibuf_rs2[RB*w +: RB]   = h_rs2[w];
      ibuf_rs3[RB*w +: RB]   = h_rs3[w];
      ibuf_tmask[NL*w +: NL] = h_tm[w];
      ibuf_raw[IB*w +: IB]   = h_raw[w];
    end
  endtask

  task automatic model_reset();
    for (int w = 0; w < NW; w++) m_sb[w] = '0;
    m_ptr = 0; m_valid = 0; m_wid = 0;
    m_pc = '0; m_op = '0; m_rd = '0; m_rs1 = '0; m_rs2 = '0; m_rs3 = '0; m_tm = '0; m_raw = '0;
  endtask

  // A register blocks issue if a write to it is pending (register 0 never blocks).
  function automatic bit reg_ok(input int w, input logic [RB-1:0] r);
    if (r == 0) return 1'b1;
    if (!m_sb[w][r]) return 1'b1;
`ifdef ISSUE_WB_BYPASS_EN
    if (wb_valid && int'(wb_wid) == w && wb_rd == r) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic bit elig(input int w);
    return ibuf_valid[w] && reg_ok(w, h_rd[w]) && reg_ok(w, h_rs1[w])
           && reg_ok(w, h_rs2[w]) && reg_ok(w, h_rs3[w]);
  endfunction

  // One clock cycle: check outputs mid-cycle against the model, then advance the model at the edge.
  task automatic step();
    int g;
    bit adv;
    logic [NW-1:0] exp_rdy;
    logic [NW-1:0] exp_busy;
    pack();
    #1;
    adv = !m_valid || issue_ready;
    g = -1;
    if (!reset && adv) begin
      for (int k = 0; k < NW; k++) begin
        int w;
        w = (m_ptr + k) % NW;
        if (g < 0 && elig(w)) g = w;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    for (int w = 0; w < NW; w++) exp_busy[w] = |m_sb[w];
    chk("ibuf_ready", 64'(ibuf_ready), 64'(exp_rdy));
    chk("sb_busy", 64'(sb_busy), 64'(exp_busy));
    chk("issue_valid", 64'(issue_valid), 64'(m_valid));
    if (m_valid) begin
      chk("issue_wid", 64'(issue_wid), 64'(m_wid));
      chk("issue_pc", 64'(issue_pc), 64'(m_pc));
      chk("issue_op", 64'(issue_op), 64'(m_op));
      chk("issue_rd", 64'(issue_rd), 64'(m_rd));
      chk("issue_rs", 64'({issue_rs1, issue_rs2, issue_rs3}), 64'({m_rs1, m_rs2, m_rs3}));
      chk("issue_tmask", 64'(issue_tmask), 64'(m_tm));
      chk("issue_raw", issue_raw, m_raw);
    end
    @(posedge clock);
    if (reset) begin
      model_reset();
    end else begin
      if (wb_valid && wb_rd != 0) m_sb[wb_wid][wb_rd] = 1'b0;
      if (g >= 0) begin
        m_valid = 1; m_wid = g;
        m_pc = h_pc[g]; m_op = h_op[g]; m_rd = h_rd[g];
        m_rs1 = h_rs1[g]; m_rs2 = h_rs2[g]; m_rs3 = h_rs3[g];
        m_tm = h_tm[g]; m_raw = h_raw[g];
        m_ptr = (g + 1) % NW;
        if (h_rd[g] != 0) m_sb[g][h_rd[g]] = 1'b1;
        refill(g);
      end else if (adv) begin
        m_valid = 0;
      end
    end
    @(negedge clock);
  endtask

  initial begin
    logic [AL-1:0] saved_pc;
    int saved_wid;
    bit seen;

    rand_regs = 0;
    for (int w = 0; w < NW; w++) refill(w);
    reset = 1; ibuf_valid = '1; issue_ready = 1;
    wb_valid = 0; wb_wid = '0; wb_rd = '0;
    pack();
    @(posedge clock);
    @(negedge clock);
    model_reset();

    // Reset held two cycles with every head valid.
    step();
    step();
    chk("rst_issue_pc", 64'(issue_pc), 64'd0);
    chk("rst_issue_raw", issue_raw, 64'd0);
    reset = 0;
    step();
    chk("first_grant_wid", 64'(issue_wid), 64'd0);

    // Independent instructions rotate through every warp.
    for (int k = 0; k < 9; k++) begin
      step();
      chk("rr_wid", 64'(issue_wid), 64'((k + 1) % NW));
    end

    // Warp 2 writes r5, then its next head reads r5.
    h_rd[2] = 8'd5;
    seen = 0;
    for (int k = 0; k < NW && !seen; k++) begin
      step();
      if (issue_valid && issue_wid == 3'd2) seen = 1;
    end
    chk("w2_rd5_issued", 64'(seen), 64'd1);
    h_rs1[2] = 8'd5;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("w2_blocked", 64'(issue_valid && issue_wid == 3'd2), 64'd0);
      chk("w2_sb_busy", 64'(sb_busy[2]), 64'd1);
    end
    ibuf_valid = 8'b0000_0100;
    wb_valid = 1; wb_wid = 3'd2; wb_rd = 8'd5;
    step();
    wb_valid = 0;
`ifdef ISSUE_WB_BYPASS_EN
    chk("w2_bypass_grant", 64'(issue_valid && issue_wid == 3'd2), 64'd1);
    step();
`else
    chk("w2_no_early_grant", 64'(issue_valid), 64'd0);
    step();
    chk("w2_grant_after_wb", 64'(issue_valid && issue_wid == 3'd2), 64'd1);
`endif
    chk("w2_sb_clear", 64'(sb_busy), 64'd0);
    ibuf_valid = '1;
    step();

    // Downstream stall: issue stage must hold.
    issue_ready = 0;
    saved_pc = issue_pc;
    saved_wid = int'(issue_wid);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_pc", 64'(issue_pc), 64'(saved_pc));
      chk("stall_valid", 64'(issue_valid), 64'd1);
    end
    issue_ready = 1;
    step();
    chk("release_wid", 64'(issue_wid), 64'((saved_wid + 1) % NW));

    // rd=0 issues and wb_rd=0 writebacks never touch the scoreboard.
    wb_valid = 1; wb_rd = '0;
    for (int k = 0; k < 5; k++) begin
      wb_wid = WB'($urandom);
      step();
      chk("zero_reg_busy", 64'(sb_busy), 64'd0);
    end
    wb_valid = 0;

    // Reset mid-operation with sb[1][7] set and an instruction held.
    ibuf_valid = 8'b0000_0010;
    h_rd[1] = 8'd7;
    step();
    chk("w1_issue", 64'(issue_wid), 64'd1);
    issue_ready = 0;
    ibuf_valid = '1;
    step();
    chk("w1_sb_busy", 64'(sb_busy), 64'h02);
    reset = 1;
    step();
    chk("midrst_valid", 64'(issue_valid), 64'd0);
    chk("midrst_busy", 64'(sb_busy), 64'd0);
    reset = 0;
    issue_ready = 1;
    step();
    chk("midrst_ptr0", 64'(issue_wid), 64'd0);

    // Randomized traffic against the model.
    rand_regs = 1;
    for (int w = 0; w < NW; w++) refill(w);
    for (int c = 0; c < 3000; c++) begin
      int w;
      int r;
      reset = ($urandom_range(0, 399) == 0);
      ibuf_valid = NW'($urandom) | NW'($urandom);
      issue_ready = ($urandom_range(0, 9) < 7);
      wb_valid = ($urandom_range(0, 1) == 1);
      w = $urandom_range(0, NW - 1);
      r = $urandom_range(1, 7);
      wb_wid = WB'(w);
      wb_rd = m_sb[w][r] ? RB'(r) : RB'($urandom_range(0, 7));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/warp_issue_scheduler.md
Name: warp_issue_scheduler

Overview:
- Sits directly downstream of the per-warp instruction-buffer heads produced by the core frontend (ibuf_* buses).
- Each cycle it selects at most one ready warp, round-robin among warps whose head instruction is hazard-free.
- Hazard check uses a per-warp register scoreboard.
- The selected instruction is registered into a single-entry issue stage that drives the execute/operand-collect stage with a valid/ready handshake.
- Writebacks clear scoreboard bits.

Parameters:
- NUM_WARPS, 8, number of warps; WID_BITS = $clog2(NUM_WARPS)
- NUM_LANES, 16, thread-mask width
- ARCH_LEN, 32, PC width
- OP_BITS, 9, opcode width
- REG_BITS, 8, register index width; scoreboard depth is 2**REG_BITS per warp
- INST_BITS, 64, raw instruction width

Ports:
- clock input 1 clock
- reset input 1 synchronous active-high reset
- ibuf_valid input NUM_WARPS per-warp head valid
- ibuf_ready output NUM_WARPS per-warp head dequeue (one-hot or zero)
- ibuf_pc input NUM_WARPS*ARCH_LEN packed, warp g at [ARCH_LEN*g +: ARCH_LEN]
- ibuf_op input NUM_WARPS*OP_BITS packed opcodes
- ibuf_rd, ibuf_rs1, ibuf_rs2, ibuf_rs3 input NUM_WARPS*REG_BITS each, packed register indices
- ibuf_tmask input NUM_WARPS*NUM_LANES packed thread masks
- ibuf_raw input NUM_WARPS*INST_BITS packed raw instructions
- issue_valid output 1 issue stage holds an instruction
- issue_ready input 1 downstream accepts
- issue_wid output WID_BITS issuing warp
- issue_pc output ARCH_LEN
- issue_op output OP_BITS
- issue_rd, issue_rs1, issue_rs2, issue_rs3 output REG_BITS each
- issue_tmask output NUM_LANES
- issue_raw output INST_BITS
- wb_valid input 1 writeback event
- wb_wid input WID_BITS writeback warp
- wb_rd input REG_BITS register being written back
- sb_busy output NUM_WARPS OR-reduction of each warp's scoreboard (any pending write)

Behaviour:
- Reset (synchronous, active-high, clock rising edge):
  - Scoreboard all zero.
  - RR pointer = 0.
  - issue_valid = 0; all issue_* data outputs = 0.
  - ibuf_ready = 0; sb_busy = 0.
  - Reset asserted mid-operation drops any held instruction; nothing is re-fetched.
- Scoreboard: sb[w][r], 1 = write pending. Register 0 is never set.
- Hazard: warp w is eligible iff all of the following hold:
  - ibuf_valid[w] = 1
  - sb[w][rs1], sb[w][rs2], sb[w][rs3] and sb[w][rd] are all 0 (covers RAW and WAW)
  - index 0 always reads as clear.
- Eligibility uses the registered scoreboard state only. Same-cycle writeback is not visible unless ISSUE_WB_BYPASS_EN is defined.
- Advance condition: adv = !issue_valid || issue_ready.
- Grant: when adv = 1, pick the first eligible warp scanning ptr, ptr+1, … modulo NUM_WARPS.
  - ibuf_ready is one-hot on the granted warp, combinational in the same cycle.
  - ibuf_ready = 0 when adv = 0 or when no warp is eligible.
- On grant at edge:
  - Issue register loads the warp's fields and wid.
  - issue_valid <= 1.
  - ptr <= grant+1 (wraps to 0 after NUM_WARPS-1).
  - If rd != 0, sb[grant][rd] <= 1.
- adv = 1 with no grant: issue_valid <= 0; ptr unchanged.
- adv = 0: issue register and outputs hold stable (AXI-style: data stable while valid && !ready).
- Latency: ibuf head to issue_valid is 1 cycle. Throughput is 1 instruction/cycle when issue_ready is held high.
- Writeback: wb_valid at edge clears sb[wb_wid][wb_rd].
  - wb_rd = 0 is ignored.
  - Clearing an already-clear bit is harmless.
- Simultaneous set (issue) and clear (wb) on the same warp/reg: set wins. This only arises with the bypass enabled.
- sb_busy[w] = |sb[w], registered view.
- Out-of-range wb_wid (≥ NUM_WARPS when not a power of two) is ignored.

Optional Feature:
- Macro ISSUE_WB_BYPASS_EN.
- Defined: a writeback in the current cycle is treated as already cleared for eligibility, so a dependent instruction can be granted that same cycle. Scoreboard update order: clear first, then set (set wins).
- Undefined: a dependent instruction issues no earlier than the cycle after the wb edge.

Test Plan:
1. Reset held 2 cycles with all ibuf_valid = 1 -> issue_valid = 0, ibuf_ready = 0, sb_busy = 0. First post-reset cycle grants warp 0.
2. All 8 warps valid, independent regs (rd = 0), issue_ready = 1 -> grants 0,1,2,…,7,0 on consecutive cycles; issue_wid matches each cycle.
3. Warp 2 issues rd = 5, next head rs1 = 5, no wb -> warp 2 blocked, sb_busy[2] = 1, other warps still granted. wb_valid with wid = 2, rd = 5 -> warp 2 granted the cycle after the wb edge, or the same cycle with ISSUE_WB_BYPASS_EN.
4. issue_ready = 0 for 3 cycles with issue_valid = 1 -> issue_* stable, ibuf_ready = 0. On issue_ready = 1, the next grant loads in the same edge.
5. rd = 0 instruction, and wb_rd = 0 -> scoreboard never set; sb_busy stays 0.
6. Reset asserted while issue_valid = 1 and sb[1][7] = 1 -> after the edge, issue_valid = 0, sb_busy = 0, ptr = 0.
